// File: rtl/drv_display_mux.sv
// Time-multiplexed 7-segment driver: scans NDIG digits, captures inputs once per frame,
// with leading-zero blanking, PWM brightness, special glyphs and selectable polarities.
module drv_display_mux #(
    parameter int NDIG           = 3,
    parameter int PRESC          = 50000,
    parameter int BW             = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit EN_ACTIVE_LOW  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NDIG*5-1:0] digits,
    input  logic              blank_lz,
    input  logic [BW-1:0]     brightness,
    output logic [6:0]        segmentos,
    output logic [NDIG-1:0]   enable,
    output logic              frame_start
);

    localparam int          CW      = $clog2(PRESC);
    localparam int          IW      = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [31:0] STEP    = 32'(PRESC >> BW);
    localparam logic [6:0]  SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [NDIG*5-1:0] snap_digits;
    logic              snap_blz;
    logic [BW-1:0]     snap_bright;

    logic              cnt_last;
    logic              idx_last;
    logic [NDIG-1:0]   lz_mask;
    logic              lz_run;
    logic [4:0]        cur_code;
    logic              cur_blank;
    logic              lit_now;
    logic [6:0]        pattern;
    logic [NDIG-1:0]   onehot;

    function automatic logic [6:0] decode(input logic [4:0] code);
        case (code)
            5'd0:    decode = 7'h3F;
            5'd1:    decode = 7'h06;
            5'd2:    decode = 7'h5B;
            5'd3:    decode = 7'h4F;
            5'd4:    decode = 7'h66;
            5'd5:    decode = 7'h6D;
            5'd6:    decode = 7'h7D;
            5'd7:    decode = 7'h07;
            5'd8:    decode = 7'h7F;
            5'd9:    decode = 7'h6F;
            5'd10:   decode = 7'h77;
            5'd11:   decode = 7'h7C;
            5'd12:   decode = 7'h39;
            5'd13:   decode = 7'h5E;
            5'd14:   decode = 7'h79;
            5'd15:   decode = 7'h71;
            5'd17:   decode = 7'h40;
            5'd18:   decode = 7'h08;
            default: decode = 7'h00;
        endcase
    endfunction

    assign cnt_last = (cnt == CW'(PRESC - 1));
    assign idx_last = (idx == IW'(NDIG - 1));

    // Scan position and the once-per-frame snapshot that keeps the display tear-free
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= '0;
            snap_digits <= '0;
            snap_blz    <= 1'b0;
            snap_bright <= '0;
        end else begin
            if (cnt_last) begin
                cnt <= '0;
                idx <= idx_last ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (cnt_last && idx_last) begin
                snap_digits <= digits;
                snap_blz    <= blank_lz;
                snap_bright <= brightness;
            end
        end
    end

    // Zeros are blanked from the top digit down until the first non-zero code
    always_comb begin
        lz_mask = '0;
        lz_run  = 1'b1;
        for (int i = NDIG - 1; i >= 1; i--) begin
            lz_run     = lz_run && (snap_digits[5*i +: 5] == 5'd0);
            lz_mask[i] = lz_run && snap_blz;
        end
    end

    always_comb begin
        cur_code  = '0;
        cur_blank = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx == IW'(i)) begin
                cur_code  = snap_digits[5*i +: 5];
                cur_blank = lz_mask[i];
            end
        end
        lit_now = (&snap_bright) || (32'(cnt) < 32'(snap_bright) * STEP);
        pattern = cur_blank ? 7'h00 : decode(cur_code);
        onehot  = '0;
        for (int i = 0; i < NDIG; i++) begin
            onehot[i] = (idx == IW'(i)) && !cur_blank && lit_now;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            segmentos   <= SEG_OFF;
            enable      <= EN_ACTIVE_LOW ? '1 : '0;
            frame_start <= 1'b0;
        end else begin
            segmentos   <= SEG_ACTIVE_LOW ? ~pattern : pattern;
            enable      <= EN_ACTIVE_LOW ? ~onehot : onehot;
            frame_start <= (cnt == '0) && (idx == '0);
        end
    end

endmodule
